// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle of pipeline-status inputs and hazard-control outputs exchanged
//   between the 5-stage core and its hazard/sequencing controller.
//
//   master : the pipeline side. It drives the decode/execute/memory status
//            and receives the forward selects, stalls, flushes and redirects.
//   slave  : the hazard controller. It is the mirror image of master.
//
//   Status  : ra1D, ra2D, use1D, use2D, dstE, regwriteE, memreadE, dstM,
//             regwriteM, memreadM, branchD, trapM, i_busy, d_busy
//   Control : sctl_ac, sctl_bc, stallF/D/E/M, flushD/E/M/W, redirect_trap,
//             squash_fetch, stall_cnt (STALL_CNT_W bits)
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int STALL_CNT_W = 32
);
  logic [4:0]             ra1D;
  logic [4:0]             ra2D;
  logic                   use1D;
  logic                   use2D;
  logic [4:0]             dstE;
  logic                   regwriteE;
  logic                   memreadE;
  logic [4:0]             dstM;
  logic                   regwriteM;
  logic                   memreadM;
  logic                   branchD;
  logic                   trapM;
  logic                   i_busy;
  logic                   d_busy;

  logic [1:0]             sctl_ac;
  logic [1:0]             sctl_bc;
  logic                   stallF;
  logic                   stallD;
  logic                   stallE;
  logic                   stallM;
  logic                   flushD;
  logic                   flushE;
  logic                   flushM;
  logic                   flushW;
  logic                   redirect_trap;
  logic                   squash_fetch;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output ra1D, ra2D, use1D, use2D, dstE, regwriteE, memreadE,
           dstM, regwriteM, memreadM, branchD, trapM, i_busy, d_busy,
    input  sctl_ac, sctl_bc, stallF, stallD, stallE, stallM,
           flushD, flushE, flushM, flushW, redirect_trap, squash_fetch,
           stall_cnt
  );

  modport slave (
    input  ra1D, ra2D, use1D, use2D, dstE, regwriteE, memreadE,
           dstM, regwriteM, memreadM, branchD, trapM, i_busy, d_busy,
    output sctl_ac, sctl_bc, stallF, stallD, stallE, stallM,
           flushD, flushE, flushM, flushW, redirect_trap, squash_fetch,
           stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage core. Pure control:
//   decode-stage forward selects, per-stage stall/flush, wrong-path fetch
//   squashing after branch/trap redirects, and a saturating count of
//   decode-stall cycles.
//
//   clk   : core clock
//   reset : synchronous, active-high; while high every control output is
//           forced inactive and the forward selects read the register file
//   hz    : hazard_ctrl_if.slave carrying all pipeline status and control
//
//   Forward select encoding: 0 RD, 1 ALUOUTE, 2 ALUOUTM, 3 MEMDATA.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int STALL_CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    FWD_RD      = 2'd0,
    FWD_ALUOUTE = 2'd1,
    FWD_ALUOUTM = 2'd2,
    FWD_MEMDATA = 2'd3
  } fwd_sel_t;

  // RUN: normal flow. SQUASH: a wrong-path fetch is still in flight.
  // TRAP: one cycle after a redirect with no fetch in flight.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    TRAP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic redirect;
  fwd_sel_t sel_a, sel_b;

  // A load in E never forwards from E; the consumer is held by load-use and
  // picks the value up from M one cycle later.
  function automatic fwd_sel_t fwd_sel(
    input logic [4:0] src,
    input logic       src_used,
    input logic [4:0] dst_e,
    input logic       wr_e,
    input logic       rd_e,
    input logic [4:0] dst_m,
    input logic       wr_m,
    input logic       rd_m
  );
    fwd_sel_t sel;
    sel = FWD_RD;
    if (src_used && (src != 5'd0)) begin
      if (wr_e && !rd_e && (dst_e == src)) begin
        sel = FWD_ALUOUTE;
      end else if (wr_m && (dst_m == src)) begin
        sel = rd_m ? FWD_MEMDATA : FWD_ALUOUTM;
      end
    end
    return sel;
  endfunction

  always_comb begin
    sel_a = fwd_sel(hz.ra1D, hz.use1D, hz.dstE, hz.regwriteE, hz.memreadE,
                    hz.dstM, hz.regwriteM, hz.memreadM);
    sel_b = fwd_sel(hz.ra2D, hz.use2D, hz.dstE, hz.regwriteE, hz.memreadE,
                    hz.dstM, hz.regwriteM, hz.memreadM);
  end

  // Load-use only matters while the decode instruction is on the correct
  // path; in SQUASH/TRAP the D slot is being flushed anyway.
  always_comb begin
    lu = (state_q == RUN) && hz.memreadE && hz.regwriteE && (hz.dstE != 5'd0) &&
         ((hz.use1D && (hz.ra1D == hz.dstE)) ||
          (hz.use2D && (hz.ra2D == hz.dstE)));
  end

  // Stall/flush arbitration, highest priority first: dcache busy freezes the
  // whole pipe, then a trap redirect, then load-use, then branch/icache.
  // A trap presented during the TRAP cycle is the same trap and is ignored.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_w  = 1'b0;
    redirect = 1'b0;
    if (!reset) begin
      if (hz.d_busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.trapM && (state_q != TRAP)) begin
        flush_d  = 1'b1;
        flush_e  = 1'b1;
        flush_m  = 1'b1;
        redirect = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        if (state_q != RUN) flush_d = 1'b1;
        if ((state_q == RUN) && hz.branchD) flush_d = 1'b1;
        if (hz.i_busy) begin
          stall_f = 1'b1;
          flush_d = 1'b1;
        end
      end
    end
  end

  // Next-state logic. While the dcache holds the pipe nothing advances, so
  // the sequencer freezes too and re-evaluates once d_busy drops.
  always_comb begin
    state_d = state_q;
    if (!hz.d_busy) begin
      case (state_q)
        RUN: begin
          if (hz.trapM) begin
            state_d = hz.i_busy ? SQUASH : TRAP;
          end else if (hz.branchD && !lu && hz.i_busy) begin
            state_d = SQUASH;
          end
        end
        SQUASH: begin
          if (!hz.trapM && !hz.i_busy) state_d = RUN;
        end
        TRAP: begin
          state_d = hz.i_busy ? SQUASH : RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.sctl_ac       = reset ? FWD_RD : sel_a;
  assign hz.sctl_bc       = reset ? FWD_RD : sel_b;
  assign hz.stallF        = stall_f;
  assign hz.stallD        = stall_d;
  assign hz.stallE        = stall_e;
  assign hz.stallM        = stall_m;
  assign hz.flushD        = flush_d;
  assign hz.flushE        = flush_e;
  assign hz.flushM        = flush_m;
  assign hz.flushW        = flush_w;
  assign hz.redirect_trap = redirect;
  assign hz.squash_fetch  = !reset && (state_q == SQUASH);
  assign hz.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed walk through the hazard scenarios followed by a randomized run,
//   each cycle compared against a rule-level reference model. A second
//   instance with a 3-bit counter shares the stimulus so counter saturation
//   is reachable.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int M_RUN    = 0;
  localparam int M_SQUASH = 1;
  localparam int M_TRAP   = 2;
  localparam longint BIG_MAX   = (longint'(1) << 32) - 1;
  localparam int     SMALL_MAX = 7;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ra1D, ra2D, dstE, dstM;
  logic use1D, use2D, regwriteE, memreadE, regwriteM, memreadM;
  logic branchD, trapM, i_busy, d_busy;

  int checks = 0;
  int errors = 0;

  int     mode;
  longint cnt_big;
  int     cnt_small;

  int exp_ac, exp_bc;
  bit exp_stallF, exp_stallD, exp_stallE, exp_stallM;
  bit exp_flushD, exp_flushE, exp_flushM, exp_flushW;
  bit exp_redirect, exp_squash, model_lu;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.STALL_CNT_W(32)) if0 ();
  hazard_ctrl_if #(.STALL_CNT_W(3))  if1 ();

  assign if0.ra1D = ra1D;           assign if1.ra1D = ra1D;
  assign if0.ra2D = ra2D;           assign if1.ra2D = ra2D;
  assign if0.use1D = use1D;         assign if1.use1D = use1D;
  assign if0.use2D = use2D;         assign if1.use2D = use2D;
  assign if0.dstE = dstE;           assign if1.dstE = dstE;
  assign if0.regwriteE = regwriteE; assign if1.regwriteE = regwriteE;
  assign if0.memreadE = memreadE;   assign if1.memreadE = memreadE;
  assign if0.dstM = dstM;           assign if1.dstM = dstM;
  assign if0.regwriteM = regwriteM; assign if1.regwriteM = regwriteM;
  assign if0.memreadM = memreadM;   assign if1.memreadM = memreadM;
  assign if0.branchD = branchD;     assign if1.branchD = branchD;
  assign if0.trapM = trapM;         assign if1.trapM = trapM;
  assign if0.i_busy = i_busy;       assign if1.i_busy = i_busy;
  assign if0.d_busy = d_busy;       assign if1.d_busy = d_busy;

  hazard_ctrl #(.STALL_CNT_W(32)) dut (.clk(clk), .reset(reset), .hz(if0.slave));
  hazard_ctrl #(.STALL_CNT_W(3))  dut_small (.clk(clk), .reset(reset), .hz(if1.slave));

  // Youngest producer wins; a load still in E has no data to give.
  function automatic int fwdExpect(input logic [4:0] src, input logic used);
    if (!used || src == 5'd0) return 0;
    if (regwriteE && !memreadE && dstE == src) return 1;
    if (regwriteM && dstM == src) return memreadM ? 3 : 2;
    return 0;
  endfunction

  task automatic computeExpected();
    bit d_valid;
    exp_ac = 0; exp_bc = 0;
    exp_stallF = 0; exp_stallD = 0; exp_stallE = 0; exp_stallM = 0;
    exp_flushD = 0; exp_flushE = 0; exp_flushM = 0; exp_flushW = 0;
    exp_redirect = 0; exp_squash = 0; model_lu = 0;
    if (reset) return;
    exp_ac = fwdExpect(ra1D, use1D);
    exp_bc = fwdExpect(ra2D, use2D);
    exp_squash = (mode == M_SQUASH);
    d_valid = (mode == M_RUN);
    model_lu = d_valid && memreadE && regwriteE && dstE != 0 &&
               ((use1D && ra1D == dstE) || (use2D && ra2D == dstE));
    if (d_busy) begin
      exp_stallF = 1; exp_stallD = 1; exp_stallE = 1; exp_stallM = 1;
      exp_flushW = 1;
    end else if (trapM && mode != M_TRAP) begin
      exp_flushD = 1; exp_flushE = 1; exp_flushM = 1; exp_redirect = 1;
    end else if (model_lu) begin
      exp_stallF = 1; exp_stallD = 1; exp_flushE = 1;
    end else begin
      exp_flushD = !d_valid || branchD || i_busy;
      exp_stallF = i_busy;
    end
  endtask

  task automatic modelUpdate();
    computeExpected();
    if (reset) begin
      mode = M_RUN; cnt_big = 0; cnt_small = 0;
    end else begin
      if (exp_stallD) begin
        if (cnt_big < BIG_MAX) cnt_big++;
        if (cnt_small < SMALL_MAX) cnt_small++;
      end
      if (!d_busy) begin
        if (mode == M_RUN) begin
          if (trapM) mode = i_busy ? M_SQUASH : M_TRAP;
          else if (branchD && !model_lu && i_busy) mode = M_SQUASH;
        end else if (mode == M_SQUASH) begin
          if (!trapM && !i_busy) mode = M_RUN;
        end else begin
          mode = i_busy ? M_SQUASH : M_RUN;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll();
    computeExpected();
    checkOutput("sctl_ac", if0.sctl_ac, exp_ac);
    checkOutput("sctl_bc", if0.sctl_bc, exp_bc);
    checkOutput("stallF", if0.stallF, exp_stallF);
    checkOutput("stallD", if0.stallD, exp_stallD);
    checkOutput("stallE", if0.stallE, exp_stallE);
    checkOutput("stallM", if0.stallM, exp_stallM);
    checkOutput("flushD", if0.flushD, exp_flushD);
    checkOutput("flushE", if0.flushE, exp_flushE);
    checkOutput("flushM", if0.flushM, exp_flushM);
    checkOutput("flushW", if0.flushW, exp_flushW);
    checkOutput("redirect_trap", if0.redirect_trap, exp_redirect);
    checkOutput("squash_fetch", if0.squash_fetch, exp_squash);
    checkOutput("stall_cnt", if0.stall_cnt, cnt_big);
    checkOutput("stall_cnt_small", if1.stall_cnt, cnt_small);
  endtask

  // Inputs are set one time unit after the rising edge; outputs are
  // compared three units later, well clear of either clock edge.
  task automatic applyStimulus();
    #3;
    compareAll();
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic clearInputs();
    reset = 0;
    ra1D = 0; ra2D = 0; use1D = 0; use2D = 0;
    dstE = 0; regwriteE = 0; memreadE = 0;
    dstM = 0; regwriteM = 0; memreadM = 0;
    branchD = 0; trapM = 0; i_busy = 0; d_busy = 0;
  endtask

  initial begin
    mode = M_RUN; cnt_big = 0; cnt_small = 0;
    clearInputs();
    reset = 1;
    @(posedge clk); #1;

    // Reset state
    reset = 1; i_busy = 1; trapM = 1; use1D = 1; ra1D = 3; dstE = 3; regwriteE = 1;
    applyStimulus();
    checkOutput("reset_ac", if0.sctl_ac, 0);
    checkOutput("reset_redirect", if0.redirect_trap, 0);
    tick();
    clearInputs();
    applyStimulus();
    checkOutput("reset_cnt", if0.stall_cnt, 0);
    tick();

    // Forwarding priority
    ra1D = 5; use1D = 1; dstE = 5; regwriteE = 1; dstM = 5; regwriteM = 1;
    applyStimulus();
    checkOutput("fwd_E_over_M", if0.sctl_ac, 1);
    tick();
    regwriteE = 0; memreadM = 1;
    applyStimulus();
    checkOutput("fwd_M_load", if0.sctl_ac, 3);
    tick();
    memreadM = 0; ra2D = 5; use2D = 1;
    applyStimulus();
    checkOutput("fwd_M_alu", if0.sctl_bc, 2);
    tick();
    clearInputs();
    ra1D = 0; use1D = 1; dstE = 0; regwriteE = 1;
    applyStimulus();
    checkOutput("fwd_x0", if0.sctl_ac, 0);
    tick();

    // Load-use
    clearInputs();
    memreadE = 1; regwriteE = 1; dstE = 7; ra2D = 7; use2D = 1;
    applyStimulus();
    checkOutput("lu_stallF", if0.stallF, 1);
    checkOutput("lu_stallD", if0.stallD, 1);
    checkOutput("lu_flushE", if0.flushE, 1);
    tick();
    memreadE = 0; regwriteE = 0; dstE = 0;
    dstM = 7; regwriteM = 1; memreadM = 1;
    applyStimulus();
    checkOutput("lu_next_bc", if0.sctl_bc, 3);
    checkOutput("lu_next_stallD", if0.stallD, 0);
    checkOutput("lu_cnt", if0.stall_cnt, 1);
    tick();

    // Branch during fetch miss
    clearInputs();
    branchD = 1; i_busy = 1;
    applyStimulus();
    checkOutput("br_flushD", if0.flushD, 1);
    tick();
    branchD = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("br_squash", if0.squash_fetch, 1);
      checkOutput("br_sq_flushD", if0.flushD, 1);
      tick();
    end
    i_busy = 0;
    applyStimulus();
    checkOutput("br_complete_squash", if0.squash_fetch, 1);
    checkOutput("br_complete_flushD", if0.flushD, 1);
    tick();
    applyStimulus();
    checkOutput("br_back_run", if0.squash_fetch, 0);
    checkOutput("br_run_flushD", if0.flushD, 0);
    tick();

    // Trap with no fetch in flight
    trapM = 1;
    applyStimulus();
    checkOutput("trap_redirect", if0.redirect_trap, 1);
    checkOutput("trap_flushM", if0.flushM, 1);
    tick();
    applyStimulus();
    checkOutput("trapst_flushD", if0.flushD, 1);
    checkOutput("trapst_redirect", if0.redirect_trap, 0);
    tick();
    trapM = 0;
    applyStimulus();
    checkOutput("trap_done_flushD", if0.flushD, 0);
    tick();

    // d_busy holds trap and branch
    d_busy = 1; trapM = 1; branchD = 1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus();
      checkOutput("dbusy_stallM", if0.stallM, 1);
      checkOutput("dbusy_flushW", if0.flushW, 1);
      checkOutput("dbusy_redirect", if0.redirect_trap, 0);
      tick();
    end
    d_busy = 0;
    applyStimulus();
    checkOutput("dbusy_release_redirect", if0.redirect_trap, 1);
    tick();
    clearInputs();
    applyStimulus();
    tick();
    applyStimulus();
    tick();

    // Reset in SQUASH
    branchD = 1; i_busy = 1;
    applyStimulus();
    tick();
    branchD = 0;
    applyStimulus();
    checkOutput("rsq_in_squash", if0.squash_fetch, 1);
    tick();
    reset = 1;
    applyStimulus();
    checkOutput("rsq_reset_cycle", if0.squash_fetch, 0);
    tick();
    reset = 0; i_busy = 0;
    applyStimulus();
    checkOutput("rsq_after", if0.squash_fetch, 0);
    checkOutput("rsq_cnt", if0.stall_cnt, 0);
    tick();

    // Saturation on the narrow counter
    memreadE = 1; regwriteE = 1; dstE = 9; ra1D = 9; use1D = 1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      tick();
    end
    applyStimulus();
    checkOutput("sat_small", if1.stall_cnt, 7);
    checkOutput("sat_big", if0.stall_cnt, 10);
    tick();
    applyStimulus();
    checkOutput("sat_small_hold", if1.stall_cnt, 7);
    tick();

    // Randomized run
    for (int n = 0; n < 800; n++) begin
      reset     = ($urandom_range(0, 99) < 3);
      ra1D      = 5'($urandom_range(0, 3));
      ra2D      = 5'($urandom_range(0, 3));
      use1D     = 1'($urandom_range(0, 1));
      use2D     = 1'($urandom_range(0, 1));
      dstE      = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      memreadE  = ($urandom_range(0, 3) == 0);
      dstM      = 5'($urandom_range(0, 3));
      regwriteM = 1'($urandom_range(0, 1));
      memreadM  = 1'($urandom_range(0, 1));
      branchD   = ($urandom_range(0, 4) == 0);
      trapM     = ($urandom_range(0, 9) == 0);
      i_busy    = ($urandom_range(0, 9) < 4);
      d_busy    = ($urandom_range(0, 9) < 2);
      applyStimulus();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Drives the decode-stage forwarding selects (the `ac`/`bc` fields of `supercontrol_t`: RD, ALUOUTE, ALUOUTM, MEMDATA).
- Generates per-stage stall/flush for load-use, cache-busy and branch hazards.
- Squashes wrong-path fetches that are in flight when a branch or trap redirects the PC, and sequences trap/mret redirects.
- Sits beside the pipeline registers; purely control, no data path.

Parameters:
- STALL_CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ra1D  in  5  decode rs1 (`creg_addr_t`)
- ra2D  in  5  decode rs2
- use1D  in  1  D instr reads rs1
- use2D  in  1  D instr reads rs2
- dstE  in  5  E destination
- regwriteE  in  1  E writes reg
- memreadE  in  1  E is load
- dstM  in  5  M destination
- regwriteM  in  1  M writes reg
- memreadM  in  1  M is load
- branchD  in  1  taken branch/jump resolved in D
- trapM  in  1  csr.error or is_mret valid in M
- i_busy  in  1  fetch waiting on icache
- d_busy  in  1  M waiting on dcache
- sctl_ac  out  2  rs1 forward select
- sctl_bc  out  2  rs2 forward select
- stallF, stallD, stallE, stallM  out  1 each  hold stage register
- flushD, flushE, flushM, flushW  out  1 each  load bubble into stage register
- redirect_trap  out  1  PC takes trap/mret vector this cycle
- squash_fetch  out  1  returning fetch is wrong-path; discard
- stall_cnt  out  STALL_CNT_W  cycles with stallD=1, saturating

Behaviour:
Forwarding (combinational, per source):
- x0 or use=0: RD.
- Priority order for a nonzero, used source:
  - E match with regwriteE & !memreadE: ALUOUTE.
  - Else M match with regwriteM: MEMDATA if memreadM, else ALUOUTM.
  - Else RD.

Load-use:
- Condition: memreadE & regwriteE & dstE!=0 & dstE matches a used source.
- Response: lu=1, giving stallF=stallD=1 and flushE=1, for exactly one cycle; the next cycle forwards MEMDATA from M.

Priority when hazards coincide (highest first):
1. d_busy: stallF/D/E/M=1, flushW=1, all other flushes 0. branchD and trapM are ignored while held; they are re-presented next cycle.
2. trapM (state RUN): flushD/E/M=1, redirect_trap=1 for one cycle. The trap instr itself advances to W.
3. lu: as above; branchD is ignored (stale operands).
4. branchD: flushD=1, unless i_busy.
5. i_busy: stallF=1, flushD=1.

FSM states RUN, SQUASH, TRAP (reset -> RUN):
- RUN -> SQUASH: (branchD & !lu) or trapM while i_busy=1 and d_busy=0. The fetch in flight is wrong-path.
- RUN -> TRAP: trapM & !i_busy & !d_busy.
- SQUASH: squash_fetch=1 and flushD=1 every cycle. Exit to RUN on the first cycle with i_busy=0 (completion cycle, still flushed).
- TRAP: one cycle; flushD=1 (holds off the pre-redirect fetch). trapM is ignored. Next state is SQUASH if i_busy, else RUN.
- SQUASH while d_busy: d_busy stall rules win, but squash_fetch stays 1.
- A new trapM in SQUASH re-asserts redirect_trap and stays in SQUASH.

stall_cnt:
- Increments when stallD=1; saturates at all-ones.
- Reset to 0; the reset cycle does not count.

Reset values:
- Reset asserted: all stall/flush/redirect/squash outputs 0, sctl_* = RD, state=RUN, stall_cnt=0.
- Reset mid-SQUASH drops the squash immediately.

Test Plan:
- Forward priority: E(dst=5, ALU) and M(dst=5) both match ra1D=5 -> sctl_ac=ALUOUTE; M only with memreadM -> MEMDATA; ra1D=0 with dstE=0 regwriteE -> RD.
- Load-use: memreadE dstE=7, ra2D=7 use2D -> one cycle stallF=stallD=flushE=1, next cycle sctl_bc=MEMDATA, stall_cnt=1.
- Branch during fetch miss: branchD=1, i_busy=1 for 3 cycles -> SQUASH; squash_fetch=1 for 3 cycles plus completion cycle, flushD=1 each; back to RUN.
- Trap: trapM=1, i_busy=0 -> redirect_trap=1, flushD/E/M=1 that cycle; TRAP next cycle flushD=1; then RUN.
- d_busy with trapM and branchD=1 for 2 cycles -> all stalls=1, flushW=1, redirect_trap=0; cycle 3 d_busy=0 -> redirect_trap=1.
- Reset in SQUASH -> next cycle squash_fetch=0, stall_cnt=0; counter at 2^32-1 with stallD stays saturated.
